// File: rtl/task_return_scan.sv
// Sequential first-set-bit scanner: takes a word over valid/ready, examines STEP bits
// per cycle in the configured direction and holds the first hit on a valid/ready port.
module task_return_scan #(
    parameter int WIDTH     = 32,
    parameter int STEP      = 4,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CW = $clog2(WIDTH / STEP + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_found,
    output logic [IW-1:0] out_index,
    output logic [CW-1:0] out_cycles
);

    localparam int NCHUNK = WIDTH / STEP;

    generate
        if (STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_step
            $error("task_return_scan: WIDTH (%0d) must be a multiple of STEP (%0d)", WIDTH, STEP);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] word;      // unscanned bits, next chunk always in the low STEP bits
    logic [WIDTH-1:0] word_ord;
    logic [CW-1:0]   cnt;        // doubles as the chunk pointer: both start at 0 and step together
    logic [IW:0]     hit;
    logic            hit_found;
    logic [IW-1:0]   hit_off;
    logic [IW-1:0]   scan_pos;
    logic [IW-1:0]   abs_index;
    logic            last_chunk;

    // Early-return priority search: the lowest set bit of the chunk wins.
    function automatic logic [IW:0] first_hit(input logic [STEP-1:0] chunk);
        for (int j = 0; j < STEP; j++) begin
            if (chunk[j]) return {1'b1, IW'(j)};
        end
        return '0;
    endfunction

    // MSB-first mode bit-reverses the word once at capture so the scan itself is direction-free.
    always_comb begin
        word_ord = in_data;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) word_ord[i] = in_data[WIDTH-1-i];
        end
    end

    assign hit        = first_hit(word[STEP-1:0]);
    assign hit_found  = hit[IW];
    assign hit_off    = hit[IW-1:0];
    assign scan_pos   = IW'(int'(cnt) * STEP + int'(hit_off));
    assign abs_index  = MSB_FIRST ? (IW'(WIDTH - 1) - scan_pos) : scan_pos;
    assign last_chunk = (cnt == CW'(NCHUNK - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SCAN;
            SCAN:    if (hit_found || last_chunk) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            out_found  <= 1'b0;
            out_index  <= '0;
            out_cycles <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                cnt <= '0;
            end else if (state == SCAN) begin
                cnt <= cnt + CW'(1);
                if (hit_found) begin
                    out_found  <= 1'b1;
                    out_index  <= abs_index;
                    out_cycles <= cnt + CW'(1);
                end else if (last_chunk) begin
                    out_found  <= 1'b0;
                    out_index  <= '0;
                    out_cycles <= cnt + CW'(1);
                end
            end
        end
    end

    // NOTE: the word shifter carries no reset; it is always loaded before it is examined.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) word <= word_ord;
        else if (state == SCAN)        word <= word >> STEP;
    end

endmodule

// File: tb/tb_task_return_scan.sv
// Bench for task_return_scan: an LSB-first and an MSB-first instance (WIDTH=32, STEP=4)
// checked every cycle against a transaction-level reference model, plus literal pins.
module tb_task_return_scan;

    localparam int W = 32;
    localparam int S = 4;

    logic            clk;
    logic            rst_n;
    logic [1:0]      in_valid;
    logic [1:0]      in_ready;
    logic [1:0][W-1:0] in_data;
    logic [1:0]      out_valid;
    logic [1:0]      out_ready;
    logic [1:0]      out_found;
    logic [1:0][4:0] out_index;
    logic [1:0][3:0] out_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    task_return_scan #(.WIDTH(W), .STEP(S), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_found(out_found[0]),
        .out_index(out_index[0]), .out_cycles(out_cycles[0])
    );

    task_return_scan #(.WIDTH(W), .STEP(S), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_found(out_found[1]),
        .out_index(out_index[1]), .out_cycles(out_cycles[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: walk bit positions in scan order; the chunk of the first hit gives the cycle count.
    function automatic void ref_scan(input logic [W-1:0] w, input bit msb,
                                     output logic f, output int idx, output int cyc);
        f = 1'b0; idx = 0; cyc = W / S;
        for (int p = 0; p < W; p++) begin
            int b;
            b = msb ? (W - 1 - p) : p;
            if (w[b]) begin
                f = 1'b1; idx = b; cyc = p / S + 1;
                return;
            end
        end
    endfunction

    // Per-instance transaction model: 0 idle, 1 scanning with m_rem edges left, 2 result held.
    int   m_ph[2], m_rem[2], m_index[2], m_cycles[2], p_index[2], p_cycles[2];
    logic m_found[2], p_found[2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = 0; m_rem[d] = 0; m_found[d] = 1'b0; m_index[d] = 0; m_cycles[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    m_ph[d] = 0; m_found[d] = 1'b0; m_index[d] = 0; m_cycles[d] = 0;
                end
                check($sformatf("d%0d in_ready", d),   in_ready[d],   m_ph[d] == 0);
                check($sformatf("d%0d out_valid", d),  out_valid[d],  m_ph[d] == 2);
                check($sformatf("d%0d out_found", d),  out_found[d],  m_found[d]);
                check($sformatf("d%0d out_index", d),  out_index[d],  m_index[d]);
                check($sformatf("d%0d out_cycles", d), out_cycles[d], m_cycles[d]);
                if (rst_n) begin
                    case (m_ph[d])
                        0: if (in_valid[d]) begin
                            ref_scan(in_data[d], d == 1, p_found[d], p_index[d], p_cycles[d]);
                            m_rem[d] = p_cycles[d];
                            m_ph[d]  = 1;
                        end
                        1: begin
                            m_rem[d]--;
                            if (m_rem[d] == 0) begin
                                m_ph[d] = 2;
                                m_found[d] = p_found[d]; m_index[d] = p_index[d]; m_cycles[d] = p_cycles[d];
                            end
                        end
                        default: if (out_ready[d]) m_ph[d] = 0;
                    endcase
                end
            end
        end
    end

    // Called at 1ns after a rising edge; returns the result and the edges from accept to out_valid.
    task automatic send(input int d, input logic [W-1:0] w, input int hold,
                        output logic f, output int idx, output int cyc, output int lat);
        int budget;
        in_valid[d] = 1'b1;
        in_data[d]  = w;
        budget = 0;
        while (!in_ready[d] && budget < 50) begin
            @(posedge clk); #1; budget++;
        end
        check($sformatf("d%0d accept", d), in_ready[d], 1'b1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_data[d]  = $urandom();
        lat = 0;
        while (!out_valid[d] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        f   = out_found[d];
        idx = int'(out_index[d]);
        cyc = int'(out_cycles[d]);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    logic f;
    int   idx, cyc, lat, budget;
    logic ef;
    int   eidx, ecyc;
    logic [W-1:0] w;

    initial begin
        rst_n = 1'b0; in_valid = '0; out_ready = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",   in_ready[0],   1'b1);
        check("reset out_valid",  out_valid[0],  1'b0);
        check("reset out_found",  out_found[0],  1'b0);
        check("reset out_index",  out_index[0],  5'd0);
        check("reset out_cycles", out_cycles[0], 4'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(0, 32'h0000_0001, 0, f, idx, cyc, lat);
        check("bit0 found", f, 1'b1); check("bit0 index", idx, 0);
        check("bit0 cycles", cyc, 1);  check("bit0 latency", lat, 1);
        send(0, 32'h8000_0000, 1, f, idx, cyc, lat);
        check("bit31 found", f, 1'b1); check("bit31 index", idx, 31);
        check("bit31 cycles", cyc, 8); check("bit31 latency", lat, 8);
        send(0, 32'h0000_0000, 0, f, idx, cyc, lat);
        check("zero found", f, 1'b0); check("zero index", idx, 0); check("zero cycles", cyc, 8);
        send(0, 32'h0001_0100, 0, f, idx, cyc, lat);
        check("lsb 0x10100 index", idx, 8); check("lsb 0x10100 cycles", cyc, 3);
        send(1, 32'h0001_0100, 0, f, idx, cyc, lat);
        check("msb 0x10100 index", idx, 16); check("msb 0x10100 cycles", cyc, 4);
        send(1, 32'h0000_0001, 2, f, idx, cyc, lat);
        check("msb bit0 index", idx, 0); check("msb bit0 cycles", cyc, 8);
        send(1, 32'hF000_0000, 0, f, idx, cyc, lat);
        check("msb priority index", idx, 31); check("msb priority cycles", cyc, 1);

        // Back-pressure: a second word stays offered while the first result is held.
        in_valid[0] = 1'b1; in_data[0] = 32'h0000_0010;
        @(posedge clk); #1;
        in_data[0] = 32'h0000_0002;
        budget = 0;
        while (!out_valid[0] && budget < 50) begin @(posedge clk); #1; budget++; end
        repeat (5) begin
            @(posedge clk); #1;
            check("hold out_valid", out_valid[0], 1'b1);
            check("hold in_ready",  in_ready[0],  1'b0);
            check("hold out_index", out_index[0], 5'd4);
            check("hold out_cycles", out_cycles[0], 4'd2);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("taken out_valid", out_valid[0], 1'b0);
        check("taken in_ready",  in_ready[0],  1'b1);
        check("taken keeps index", out_index[0], 5'd4);
        @(posedge clk); #1;
        check("second accepted", in_ready[0], 1'b0);
        in_valid[0] = 1'b0;
        budget = 0;
        while (!out_valid[0] && budget < 50) begin @(posedge clk); #1; budget++; end
        check("second index", out_index[0], 5'd1);
        check("second cycles", out_cycles[0], 4'd1);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;

        // Reset in the middle of a full-length scan.
        in_valid[0] = 1'b1; in_data[0] = 32'h0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid[0], 1'b0);
        check("abort in_ready",  in_ready[0],  1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(0, 32'h0000_0400, 0, f, idx, cyc, lat);
        check("post-reset index", idx, 10); check("post-reset cycles", cyc, 3);

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 30; n++) begin
                case ($urandom_range(0, 3))
                    0: w = $urandom();
                    1: w = 32'h1 << $urandom_range(0, W - 1);
                    2: w = '0;
                    default: w = $urandom() & $urandom() & $urandom();
                endcase
                send(d, w, $urandom_range(0, 3), f, idx, cyc, lat);
                ref_scan(w, d == 1, ef, eidx, ecyc);
                check($sformatf("d%0d rand found", d),   f,   ef);
                check($sformatf("d%0d rand index", d),   idx, eidx);
                check($sformatf("d%0d rand cycles", d),  cyc, ecyc);
                check($sformatf("d%0d rand latency", d), lat, ecyc);
            end
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
